// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// error causes and the wait-state counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DMEM_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Listed in decreasing priority; a request reports only its highest cause.
    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_FUNCT3 = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_ALIGN  = 2'd3
    } err_cause_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core's EX/MEM stage (master) and the data
// memory responder (slave).
interface dmem_responder_if;
    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1. The master keeps req_* stable while stall_o is 1.
    // rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err hold afterwards.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall_o;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_o
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_o
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I loads and stores: byte enables,
// replicated store data, extended load data, misalignment and funct3 checks.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);
    logic [1:0]  off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane offset after dropping the low address bits that a half/word ignores.
    always_comb begin
        misaligned = 1'b0;
        off        = addr_lo;
        case (funct3[1:0])
            2'b01: begin
                misaligned = addr_lo[0];
                off        = {addr_lo[1], 1'b0};
            end
            2'b10: begin
                misaligned = |addr_lo;
                off        = 2'b00;
            end
            default: ;
        endcase
        if (we) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    end

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        case (funct3)
            F3_B: begin
                byte_en     = 4'b0001 << off;
                wdata_lanes = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en     = off[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        if (!we) begin
            byte_en = 4'b0000;
        end
    end

    assign sel_byte = rdata_raw[{off, 3'b000} +: 8];
    assign sel_half = off[1] ? rdata_raw[31:16] : rdata_raw[15:0];

    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
            F3_W:    rdata_ext = rdata_raw;
            F3_BU:   rdata_ext = {24'h0, sel_byte};
            F3_HU:   rdata_ext = {16'h0, sel_half};
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory responder with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output state_t           dbg_state,
    output err_cause_t       dbg_err_cause,
    output logic             dbg_misaligned
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [DMEM_LAT_W-1:0] LAT_INIT = DMEM_LAT_W'(LATENCY);
    localparam logic [DMEM_LAT_W-1:0] CNT_ONE  = DMEM_LAT_W'(1);

    state_t                 state;
    logic [DMEM_LAT_W-1:0]  cnt;
    logic                   we_q;
    logic [2:0]             funct3_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [31:0]            rsp_rdata_q;
    err_cause_t             err_cause_q;
    logic                   misaligned_q;

    logic                   take_inputs;
    logic                   access_fire;
    logic                   acc_we;
    logic [2:0]             acc_funct3;
    logic [31:0]            acc_addr;
    logic [31:0]            acc_wdata;
    logic [31:0]            acc_off;
    logic [IDX_W-1:0]       acc_idx;
    logic                   out_of_range;
    logic [3:0]             byte_en;
    logic [31:0]            wdata_lanes;
    logic [31:0]            rdata_ext;
    logic [31:0]            raw_word;
    logic                   misaligned;
    logic                   illegal;
    logic                   misalign_err;
    err_cause_t             acc_cause;
    logic                   mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the access happens on the accept edge itself, so
    // the operands come straight from the bus rather than the latched copy.
    assign take_inputs = (state == IDLE);
    assign access_fire = ((state == IDLE) && bus.req_valid && (LATENCY == 0)) ||
                         ((state == WAIT) && (cnt == CNT_ONE));

    assign acc_we     = take_inputs ? bus.req_we     : we_q;
    assign acc_funct3 = take_inputs ? bus.req_funct3 : funct3_q;
    assign acc_addr   = take_inputs ? bus.req_addr   : addr_q;
    assign acc_wdata  = take_inputs ? bus.req_wdata  : wdata_q;

    // Modulo-2^32 offset: addresses below BASE_ADDR wrap high and fall out of range.
    assign acc_off      = acc_addr - BASE_ADDR;
    assign out_of_range = ({1'b0, acc_off} >= SPAN);
    assign acc_idx      = acc_off[IDX_W+1:2];
    assign raw_word     = mem[acc_idx];

    dmem_lane_align u_lane_align (
        .we          (acc_we),
        .funct3      (acc_funct3),
        .addr_lo     (acc_addr[1:0]),
        .wdata       (acc_wdata),
        .rdata_raw   (raw_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned),
        .illegal     (illegal)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_err = misaligned;
`else
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        if (illegal) begin
            acc_cause = ERR_FUNCT3;
        end else if (out_of_range) begin
            acc_cause = ERR_RANGE;
        end else if (misalign_err) begin
            acc_cause = ERR_ALIGN;
        end else begin
            acc_cause = ERR_NONE;
        end
    end

    assign mem_we = access_fire && acc_we && (acc_cause == ERR_NONE);

    // Storage has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[acc_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            err_cause_q  <= ERR_NONE;
            misaligned_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (access_fire) begin
                rsp_valid_q  <= 1'b1;
                rsp_err_q    <= (acc_cause != ERR_NONE);
                rsp_rdata_q  <= (acc_we || (acc_cause != ERR_NONE)) ? 32'h0 : rdata_ext;
                err_cause_q  <= acc_cause;
                misaligned_q <= misaligned;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        cnt      <= LAT_INIT;
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RESP deasserts ready, so a request still held high is not taken twice.
    assign bus.req_ready = (state == IDLE);
    assign bus.stall_o   = ((state == IDLE) && bus.req_valid) || (state == WAIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign dbg_state      = state;
    assign dbg_err_cause  = err_cause_q;
    assign dbg_misaligned = misaligned_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance at base 0 and a zero-wait
// instance at a non-zero base, checked against a byte-addressed memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned D_L2 = 1024;
    localparam logic [31:0] B_L2 = 32'h0000_0000;
    localparam int unsigned D_L0 = 64;
    localparam logic [31:0] B_L0 = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus_l2();
    dmem_responder_if bus_l0();

    state_t     st[2];
    err_cause_t cause[2];
    logic       mis[2];

    logic        drv_valid[2];
    logic        drv_we[2];
    logic [2:0]  drv_f3[2];
    logic [31:0] drv_addr[2];
    logic [31:0] drv_wdata[2];
    logic        o_ready[2];
    logic        o_rv[2];
    logic        o_err[2];
    logic        o_stall[2];
    logic [31:0] o_rd[2];

    assign bus_l2.req_valid  = drv_valid[0];
    assign bus_l2.req_we     = drv_we[0];
    assign bus_l2.req_funct3 = drv_f3[0];
    assign bus_l2.req_addr   = drv_addr[0];
    assign bus_l2.req_wdata  = drv_wdata[0];
    assign bus_l0.req_valid  = drv_valid[1];
    assign bus_l0.req_we     = drv_we[1];
    assign bus_l0.req_funct3 = drv_f3[1];
    assign bus_l0.req_addr   = drv_addr[1];
    assign bus_l0.req_wdata  = drv_wdata[1];
    assign o_ready[0] = bus_l2.req_ready;
    assign o_rv[0]    = bus_l2.rsp_valid;
    assign o_err[0]   = bus_l2.rsp_err;
    assign o_stall[0] = bus_l2.stall_o;
    assign o_rd[0]    = bus_l2.rsp_rdata;
    assign o_ready[1] = bus_l0.req_ready;
    assign o_rv[1]    = bus_l0.rsp_valid;
    assign o_err[1]   = bus_l0.rsp_err;
    assign o_stall[1] = bus_l0.stall_o;
    assign o_rd[1]    = bus_l0.rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(D_L2), .LATENCY(2), .BASE_ADDR(B_L2)) u_l2 (
        .clk(clk), .reset(rst), .bus(bus_l2),
        .dbg_state(st[0]), .dbg_err_cause(cause[0]), .dbg_misaligned(mis[0])
    );
    dmem_responder #(.DEPTH_WORDS(D_L0), .LATENCY(0), .BASE_ADDR(B_L0)) u_l0 (
        .clk(clk), .reset(rst), .bus(bus_l0),
        .dbg_state(st[1]), .dbg_err_cause(cause[1]), .dbg_misaligned(mis[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: little-endian byte memory covering the first 256 bytes.
    logic [7:0] bmem [2][256];

    // Results of the last xact: observed, then model expectation.
    logic [31:0] r_rd;
    logic        r_e;
    int          r_lat;
    bit          r_sbad;
    bit          r_pbad;
    logic [31:0] x_rd;
    logic        x_e;

    function automatic logic [31:0] base_of(input int w);
        return (w == 0) ? B_L2 : B_L0;
    endfunction

    function automatic longint span_of(input int w);
        return (w == 0) ? longint'(D_L2) * 4 : longint'(D_L0) * 4;
    endfunction

    function automatic int lat_of(input int w);
        return (w == 0) ? 2 : 0;
    endfunction

    function automatic void model(input int w, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic e);
        logic [31:0] off;
        logic [31:0] v;
        int size;
        bit legal;
        off = a - base_of(w);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e = !legal || (longint'({32'h0, off}) >= span_of(w));
`ifdef DMEM_MISALIGN_TRAP_EN
        e = e || ((int'(a[1:0]) % size) != 0);
`endif
        rd = 32'h0;
        if (e) return;
        off = off - 32'(int'(off[1:0]) % size);
        if (we) begin
            for (int i = 0; i < size; i++) bmem[w][int'(off) + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = bmem[w][int'(off) + i];
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    // Drive one request, wait for its response and record latency, stall and
    // pulse-shape observations along with the model expectation.
    task automatic xact(input int w, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        int guard;
        model(w, we, f3, a, wd, x_rd, x_e);
        @(negedge clk);
        drv_we[w] = we; drv_f3[w] = f3; drv_addr[w] = a; drv_wdata[w] = wd;
        drv_valid[w] = 1'b1;
        #1;
        guard = 0;
        while (!o_ready[w] && guard < 40) begin
            @(negedge clk); #1; guard++;
        end
        r_sbad = !o_stall[w];
        @(posedge clk); #1;
        drv_valid[w] = 1'b0;
        r_lat = 0;
        while (!o_rv[w] && r_lat < 40) begin
            if (!o_stall[w]) r_sbad = 1'b1;
            @(posedge clk); #1;
            r_lat++;
        end
        if (o_stall[w]) r_sbad = 1'b1;
        r_rd = o_rd[w];
        r_e  = o_err[w];
        @(posedge clk); #1;
        r_pbad = o_rv[w] || (o_rd[w] !== r_rd) || (o_err[w] !== r_e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int w = 0; w < 2; w++) begin
            drv_valid[w] = 1'b0; drv_we[w] = 1'b0; drv_f3[w] = F3_W;
            drv_addr[w] = 32'h0; drv_wdata[w] = 32'h0;
        end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (o_rv[0] !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", o_rv[0]); end
        checks++; if (o_rd[0] !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", o_rd[0]); end
        checks++; if (o_err[0] !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", o_err[0]); end
        checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", o_ready[0]); end
        checks++; if (st[0] !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", st[0]); end
        checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL rst_stall_lo got %b want 0", o_stall[0]); end
        drv_valid[0] = 1'b1;
        #1;
        checks++; if (o_stall[0] !== 1'b1) begin errors++; $display("FAIL rst_stall_hi got %b want 1", o_stall[0]); end
        drv_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        int bad;
        for (int w = 0; w < 2; w++) begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                xact(w, 1'b1, F3_W, base_of(w) + 32'(4 * i), 32'h0);
                if (r_e !== 1'b0) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL init_err dut %0d got %0d errors want 0", w, bad); end
        end
    endtask

    task automatic test_sw_lw();
        xact(0, 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
        checks++; if (r_lat != 2) begin errors++; $display("FAIL sw_latency got %0d want 2", r_lat); end
        checks++; if (r_sbad) begin errors++; $display("FAIL sw_stall_window got bad want ok"); end
        checks++; if (r_pbad) begin errors++; $display("FAIL sw_pulse_hold got bad want ok"); end
        checks++; if (r_e !== 1'b0 || r_rd !== 32'h0) begin errors++; $display("FAIL sw_rsp got err=%b rd=%h want 0/0", r_e, r_rd); end
        xact(0, 1'b0, F3_W, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'hDEAD_BEEF || r_e !== 1'b0) begin errors++; $display("FAIL lw_0x10 got %h/%b want deadbeef/0", r_rd, r_e); end
    endtask

    task automatic test_byte_ops();
        xact(0, 1'b1, F3_B, 32'h21, 32'hABCD_EF80);
        checks++; if (r_e !== 1'b0) begin errors++; $display("FAIL sb_err got %b want 0", r_e); end
        xact(0, 1'b0, F3_B, 32'h21, 32'h0);
        checks++; if (r_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_0x21 got %h want ffffff80", r_rd); end
        xact(0, 1'b0, F3_BU, 32'h21, 32'h0);
        checks++; if (r_rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_0x21 got %h want 00000080", r_rd); end
        xact(0, 1'b0, F3_W, 32'h20, 32'h0);
        checks++; if (r_rd !== 32'h0000_8000) begin errors++; $display("FAIL lw_0x20 got %h want 00008000", r_rd); end
        xact(0, 1'b1, F3_H, 32'h26, 32'h5555_C001);
        xact(0, 1'b0, F3_H, 32'h26, 32'h0);
        checks++; if (r_rd !== 32'hFFFF_C001) begin errors++; $display("FAIL lh_0x26 got %h want ffffc001", r_rd); end
        xact(0, 1'b0, F3_HU, 32'h26, 32'h0);
        checks++; if (r_rd !== 32'h0000_C001) begin errors++; $display("FAIL lhu_0x26 got %h want 0000c001", r_rd); end
    endtask

    task automatic test_misaligned();
        xact(0, 1'b0, F3_W, 32'h12, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (r_e !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL lw_0x12 got %h/%b want 0/1", r_rd, r_e); end
        checks++; if (cause[0] !== ERR_ALIGN) begin errors++; $display("FAIL lw_0x12_cause got %0d want ALIGN", cause[0]); end
`else
        checks++; if (r_e !== 1'b0 || r_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_0x12 got %h/%b want deadbeef/0", r_rd, r_e); end
`endif
        checks++; if (mis[0] !== 1'b1) begin errors++; $display("FAIL lw_0x12_misflag got %b want 1", mis[0]); end
    endtask

    task automatic test_errors();
        xact(0, 1'b1, F3_W, B_L2 + 32'(D_L2 * 4), 32'h1234);
        checks++; if (r_e !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL sw_oor got %h/%b want 0/1", r_rd, r_e); end
        xact(0, 1'b0, F3_W, 32'h0, 32'h0);
        checks++; if (r_e !== 1'b0 || r_rd !== 32'h0) begin errors++; $display("FAIL word0_after_oor got %h/%b want 0/0", r_rd, r_e); end
        xact(0, 1'b0, 3'b011, 32'h10, 32'h0);
        checks++; if (r_e !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL ld_f3_011 got %h/%b want 0/1", r_rd, r_e); end
        xact(0, 1'b1, F3_BU, 32'h9000_0001, 32'h0);
        checks++; if (cause[0] !== ERR_FUNCT3) begin errors++; $display("FAIL prio_funct3 got %0d want FUNCT3", cause[0]); end
        xact(0, 1'b0, F3_W, 32'h9000_0002, 32'h0);
        checks++; if (cause[0] !== ERR_RANGE) begin errors++; $display("FAIL prio_range got %0d want RANGE", cause[0]); end
        xact(1, 1'b0, F3_W, B_L0 - 32'd4, 32'h0);
        checks++; if (r_e !== 1'b1) begin errors++; $display("FAIL below_base got %b want 1", r_e); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        drv_we[0] = 1'b1; drv_f3[0] = F3_W; drv_addr[0] = 32'h30; drv_wdata[0] = 32'hAA;
        drv_valid[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        drv_valid[0] = 1'b0;
        #1;
        checks++; if (st[0] !== IDLE) begin errors++; $display("FAIL midrst_state got %0d want IDLE", st[0]); end
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (o_rv[0]) seen++; end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (o_rv[0]) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_rsp got %0d pulses want 0", seen); end
        xact(0, 1'b0, F3_W, 32'h30, 32'h0);
        checks++; if (r_rd !== x_rd || r_rd !== 32'h0) begin errors++; $display("FAIL midrst_readback got %h want %h", r_rd, x_rd); end
    endtask

    task automatic test_back_to_back();
        int nresp;
        int bad_phase;
        int bad_data;
        int dbl;
        xact(1, 1'b1, F3_W, B_L0 + 32'h8, 32'hCAFE_F00D);
        checks++; if (r_lat != 0) begin errors++; $display("FAIL l0_latency got %0d want 0", r_lat); end
        @(negedge clk);
        drv_we[1] = 1'b0; drv_f3[1] = F3_W; drv_addr[1] = B_L0 + 32'h8;
        drv_valid[1] = 1'b1;
        nresp = 0; bad_phase = 0; bad_data = 0; dbl = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (o_rv[1]) begin
                nresp++;
                if (k % 2 == 0) bad_phase++;
                if (o_rd[1] !== 32'hCAFE_F00D) bad_data++;
                if (o_ready[1] || o_stall[1]) dbl++;
            end
        end
        drv_valid[1] = 1'b0;
        checks++; if (nresp != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", nresp); end
        checks++; if (bad_phase != 0) begin errors++; $display("FAIL b2b_phase got %0d off-phase want 0", bad_phase); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL b2b_data got %0d bad want 0", bad_data); end
        checks++; if (dbl != 0) begin errors++; $display("FAIL b2b_resp_ready got %0d want 0", dbl); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] off;
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 150; n++) begin
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    0:       off = 32'(span_of(w)) + 32'($urandom_range(0, 300));
                    1:       off = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
                    default: off = 32'($urandom_range(0, 255));
                endcase
                xact(w, we, f3, base_of(w) + off, $urandom);
                checks++; if (r_rd !== x_rd) begin errors++; $display("FAIL rnd_rdata dut %0d #%0d we=%b f3=%0d a=%h got %h want %h", w, n, we, f3, base_of(w) + off, r_rd, x_rd); end
                checks++; if (r_e !== x_e) begin errors++; $display("FAIL rnd_err dut %0d #%0d got %b want %b", w, n, r_e, x_e); end
                checks++; if (r_lat != lat_of(w) || r_sbad || r_pbad) begin errors++; $display("FAIL rnd_timing dut %0d #%0d lat %0d want %0d stall_bad %b pulse_bad %b", w, n, r_lat, lat_of(w), r_sbad, r_pbad); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_sw_lw();
        test_byte_ops();
        test_misaligned();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the load/store port of the pipelined RISC-V core from its EX/MEM stage. It accepts one request at a time and performs RV32I byte, halfword and word access with load sign/zero extension. It returns a registered response after a configurable number of wait states and drives a stall to hold the pipeline until that response arrives.

## Interface
- `DEPTH_WORDS`, 1024: storage size in 32-bit words; power of two.
- `LATENCY`, 2: wait states between accept and access; legal range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present; held stable by the core while `stall_o`=1.
- `req_ready` out 1: request accepted this cycle when `req_valid`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access size and signedness (RV32I load/store funct3).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle response pulse, for loads and stores.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: access rejected; valid with `rsp_valid`.
- `stall_o` out 1: pipeline hold request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state==IDLE).
- `stall_o` = (IDLE & `req_valid`) | WAIT.
- IDLE with `req_valid`: latch we/funct3/addr/wdata; load counter with `LATENCY`.
  - `LATENCY`=0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement counter. On the edge where the counter is 1, perform the access and go to RESP.
- Access is performed on the edge entering RESP:
  - Store writes the selected byte lanes.
  - Load registers the extended data into `rsp_rdata`.
- RESP: `rsp_valid`=1 and `req_ready`=0, so a held `req_valid` is never re-accepted. Unconditionally go to IDLE.
- Index = (addr − `BASE_ADDR`) >> 2, computed in 32-bit modulo arithmetic.
- Out of range when (addr − `BASE_ADDR`) ≥ `DEPTH_WORDS`*4. Response: `rsp_err`=1, `rsp_rdata`=0, no write.
- funct3 for loads:
  - 000 lb: sign-extend byte at addr[1:0].
  - 001 lh: sign-extend half at addr[1].
  - 010 lw: full word.
  - 100 lbu, 101 lhu: zero-extend.
  - 011, 110, 111: `rsp_err`=1.
- funct3 for stores:
  - 000 sb: lane = addr[1:0], data = wdata[7:0].
  - 001 sh: lanes addr[1]*2 and +1, data = wdata[15:0].
  - 010 sw: all lanes.
  - Any other value: `rsp_err`=1, no write.
- Misalignment (half with addr[0]=1, word with addr[1:0]≠0) is handled per the macro in Configuration.
- Reset mid-operation drops the in-flight request: no write occurs unless the access edge has already passed. Memory contents are never cleared by reset.
- Error priority: illegal funct3 > out-of-range > misaligned.

## Timing
- Reset values: state IDLE, counter 0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=1, `stall_o` follows `req_valid`.
- Accept at edge N (end of cycle N): `rsp_valid` high in cycle N+`LATENCY`+1 for exactly one cycle.
- `stall_o` is high in cycles N..N+`LATENCY` and low in the RESP cycle, so the core advances with the response data.
- Throughput: one request per `LATENCY`+2 cycles. The next request is accepted in the IDLE cycle after RESP.
- `rsp_rdata` and `rsp_err` hold their values after the `rsp_valid` pulse until the next access edge.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: misaligned access gives `rsp_err`=1, `rsp_rdata`=0, no write.
- Undefined: misaligned addresses are silently aligned (addr[0] dropped for half, addr[1:0] dropped for word) and the access proceeds with `rsp_err`=0.

## Structure
- Shared package `dmem_pkg` holds:
  - funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - FSM state enum.
  - `DMEM_LAT_W`=4.
- Sub-module `dmem_lane_align`, purely combinational, produces:
  - store: byte-enable[3:0] and shifted write data from funct3, addr[1:0], wdata.
  - load: extended read data from funct3, addr[1:0], raw word.
  - misaligned and illegal-funct3 flags.
- Storage is an inferred `DEPTH_WORDS`×32 array with a 4-bit byte-enable write.

## Test plan
- `LATENCY`=2: sw 0xDEADBEEF @0x10 accepted at cycle 0 → `rsp_valid` at cycle 3, `stall_o` high cycles 0–2; then lw @0x10 → `rsp_rdata`=0xDEADBEEF.
- sb 0x80 @0x21, then lb @0x21 → 0xFFFFFF80; lbu @0x21 → 0x00000080; lw @0x20 → 0x00008000 (word previously 0).
- lw @0x12:
  - With `DMEM_MISALIGN_TRAP_EN`: `rsp_err`=1, `rsp_rdata`=0.
  - Without it: returns the word at 0x10, `rsp_err`=0.
- sw 0x1234 @ `BASE_ADDR`+`DEPTH_WORDS`*4 → `rsp_err`=1, and a readback of word 0 is unchanged.
- `reset` pulse in WAIT of a sw 0xAA @0x30: no `rsp_valid`, state IDLE after reset, lw @0x30 returns the old value.
- `LATENCY`=0 with `req_valid` held: `rsp_valid` every 2nd cycle, and no double-accept in RESP (count exactly one response per request).
